// File: rtl/cdb_arbiter.sv
// Completion broadcast bus arbiter: per-FU holding registers, round-robin
// selection of up to WAYS entries per cycle onto a registered CDB.
module cdb_arbiter #(
  parameter int WAYS   = 3,
  parameter int NUM_FU = 6,
  parameter int ROB    = 32,
  parameter int PRF    = 64,
  parameter int XLEN   = 32
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  squash,
  input  logic [NUM_FU-1:0]                     fu_valid,
  input  logic [NUM_FU-1:0][$clog2(ROB)-1:0]    fu_rob_idx,
  input  logic [NUM_FU-1:0][$clog2(PRF)-1:0]    fu_prn,
  input  logic [NUM_FU-1:0][XLEN-1:0]           fu_value,
  input  logic [NUM_FU-1:0]                     fu_direction,
  input  logic [NUM_FU-1:0][XLEN-1:0]           fu_target,
  output logic [NUM_FU-1:0]                     fu_ready,
  output logic [WAYS-1:0]                       CDB_valid,
  output logic [WAYS-1:0][$clog2(ROB)-1:0]      CDB_ROB_idx,
  output logic [WAYS-1:0][$clog2(PRF)-1:0]      CDB_PRN,
  output logic [WAYS-1:0][XLEN-1:0]             CDB_value,
  output logic [WAYS-1:0]                       CDB_direction,
  output logic [WAYS-1:0][XLEN-1:0]             CDB_target
);

  localparam int RW = $clog2(ROB);
  localparam int PW = $clog2(PRF);
  localparam int FW = $clog2(NUM_FU);
  localparam int LW = $clog2(WAYS + 1);

  typedef struct packed {
    logic [RW-1:0]   rob;
    logic [PW-1:0]   prn;
    logic [XLEN-1:0] value;
    logic            dir;
    logic [XLEN-1:0] tgt;
  } entry_t;

  entry_t [NUM_FU-1:0] hold_q, hold_d;
  logic   [NUM_FU-1:0] hold_valid_q, hold_valid_d;
  logic   [FW-1:0]     rr_q, rr_d;
  entry_t [WAYS-1:0]   cdb_q, cdb_d;
  logic   [WAYS-1:0]   cdb_valid_q, cdb_valid_d;

  logic   [NUM_FU-1:0] grant;
  logic   [NUM_FU-1:0] accept;
  logic   [FW-1:0]     scan_idx;
  logic   [LW-1:0]     scan_n;

  // Walk all FUs from rr_q with explicit wrap; the k-th hit lands in lane k.
  always_comb begin
    grant       = '0;
    cdb_valid_d = '0;
    cdb_d       = '0;
    rr_d        = rr_q;
    scan_idx    = rr_q;
    scan_n      = '0;
    for (int unsigned j = 0; j < NUM_FU; j++) begin
      if (hold_valid_q[scan_idx] && (scan_n < LW'(WAYS))) begin
        grant[scan_idx]     = 1'b1;
        cdb_valid_d[scan_n] = 1'b1;
        cdb_d[scan_n]       = hold_q[scan_idx];
        scan_n              = scan_n + 1'b1;
        rr_d = (scan_idx == FW'(NUM_FU - 1)) ? '0 : scan_idx + 1'b1;
      end
      scan_idx = (scan_idx == FW'(NUM_FU - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  assign fu_ready = (reset || squash) ? '0 : (~hold_valid_q | grant);
  assign accept   = fu_valid & fu_ready;

  // A granted slot may be refilled on the same edge it drains.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = (hold_valid_q & ~grant) | accept;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (accept[i]) begin
        hold_d[i].rob   = fu_rob_idx[i];
        hold_d[i].prn   = fu_prn[i];
        hold_d[i].value = fu_value[i];
        hold_d[i].dir   = fu_direction[i];
        hold_d[i].tgt   = fu_target[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    hold_q <= hold_d;
    if (reset) begin
      hold_valid_q <= '0;
      rr_q         <= '0;
      cdb_valid_q  <= '0;
      cdb_q        <= '0;
    end else if (squash) begin
      hold_valid_q <= '0;
      cdb_valid_q  <= '0;
      cdb_q        <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      rr_q         <= rr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_q        <= cdb_d;
    end
  end

  always_comb begin
    CDB_valid = cdb_valid_q;
    for (int unsigned k = 0; k < WAYS; k++) begin
      CDB_ROB_idx[k]   = cdb_q[k].rob;
      CDB_PRN[k]       = cdb_q[k].prn;
      CDB_value[k]     = cdb_q[k].value;
      CDB_direction[k] = cdb_q[k].dir;
      CDB_target[k]    = cdb_q[k].tgt;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a scan-order reference model checked
// every cycle, plus literal expectations for the named scenarios.
module tb_cdb_arbiter;
  localparam int W  = 3;
  localparam int N  = 6;
  localparam int RW = 5;
  localparam int PW = 6;
  localparam int XL = 32;

  logic                    clock = 1'b0;
  logic                    reset, squash;
  logic [N-1:0]            fu_valid;
  logic [N-1:0][RW-1:0]    fu_rob_idx;
  logic [N-1:0][PW-1:0]    fu_prn;
  logic [N-1:0][XL-1:0]    fu_value;
  logic [N-1:0]            fu_direction;
  logic [N-1:0][XL-1:0]    fu_target;
  logic [N-1:0]            fu_ready;
  logic [W-1:0]            CDB_valid;
  logic [W-1:0][RW-1:0]    CDB_ROB_idx;
  logic [W-1:0][PW-1:0]    CDB_PRN;
  logic [W-1:0][XL-1:0]    CDB_value;
  logic [W-1:0]            CDB_direction;
  logic [W-1:0][XL-1:0]    CDB_target;

  cdb_arbiter #(.WAYS(W), .NUM_FU(N), .ROB(32), .PRF(64), .XLEN(XL)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fu_valid), .fu_rob_idx(fu_rob_idx), .fu_prn(fu_prn),
    .fu_value(fu_value), .fu_direction(fu_direction), .fu_target(fu_target),
    .fu_ready(fu_ready), .CDB_valid(CDB_valid), .CDB_ROB_idx(CDB_ROB_idx),
    .CDB_PRN(CDB_PRN), .CDB_value(CDB_value), .CDB_direction(CDB_direction),
    .CDB_target(CDB_target)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending table, pointer, expected CDB contents.
  bit                   m_known = 1'b0;
  bit   [N-1:0]         m_pend;
  int                   m_rr;
  logic [RW-1:0]        m_rob [N];
  logic [PW-1:0]        m_prn [N];
  logic [XL-1:0]        m_val [N];
  logic                 m_dir [N];
  logic [XL-1:0]        m_tgt [N];
  logic [W-1:0]         e_valid;
  logic [W-1:0][RW-1:0] e_rob;
  logic [W-1:0][PW-1:0] e_prn;
  logic [W-1:0][XL-1:0] e_val;
  logic [W-1:0]         e_dir;
  logic [W-1:0][XL-1:0] e_tgt;

  function automatic void model_scan(output int n, output int lane[W]);
    n = 0;
    for (int k = 0; k < W; k++) lane[k] = 0;
    for (int j = 0; j < N; j++) begin
      int f;
      f = (m_rr + j) % N;
      if (m_pend[f] && n < W) begin
        lane[n] = f;
        n++;
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int n;
    int lane[W];
    logic [N-1:0] g;
    model_scan(n, lane);
    g = '0;
    for (int k = 0; k < n; k++) g[lane[k]] = 1'b1;
    if (reset || squash) return '0;
    return ~m_pend | g;
  endfunction

  int  mn;
  int  mlane[W];
  bit  [N-1:0] m_old, m_g;

  always @(posedge clock) begin
    if (reset) begin
      m_known = 1'b1;
      m_pend = '0; m_rr = 0;
      e_valid = '0; e_rob = '0; e_prn = '0; e_val = '0; e_dir = '0; e_tgt = '0;
    end else if (m_known) begin
      if (squash) begin
        m_pend = '0;
        e_valid = '0; e_rob = '0; e_prn = '0; e_val = '0; e_dir = '0; e_tgt = '0;
      end else begin
        model_scan(mn, mlane);
        e_valid = '0; e_rob = '0; e_prn = '0; e_val = '0; e_dir = '0; e_tgt = '0;
        m_old = m_pend;
        m_g = '0;
        for (int k = 0; k < mn; k++) begin
          e_valid[k] = 1'b1;
          e_rob[k] = m_rob[mlane[k]]; e_prn[k] = m_prn[mlane[k]];
          e_val[k] = m_val[mlane[k]]; e_dir[k] = m_dir[mlane[k]];
          e_tgt[k] = m_tgt[mlane[k]];
          m_g[mlane[k]] = 1'b1;
          m_pend[mlane[k]] = 1'b0;
        end
        if (mn > 0) m_rr = (mlane[mn-1] + 1) % N;
        for (int i = 0; i < N; i++) begin
          if (fu_valid[i] && (!m_old[i] || m_g[i])) begin
            m_pend[i] = 1'b1;
            m_rob[i] = fu_rob_idx[i]; m_prn[i] = fu_prn[i];
            m_val[i] = fu_value[i]; m_dir[i] = fu_direction[i];
            m_tgt[i] = fu_target[i];
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_known) begin
      chk("cdb_bus",
          {CDB_valid, CDB_ROB_idx, CDB_PRN, CDB_value, CDB_direction, CDB_target},
          {e_valid, e_rob, e_prn, e_val, e_dir, e_tgt});
      chk("fu_ready", fu_ready, exp_ready());
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_fu(input int i, input int rob, input int prn,
                        input logic [XL-1:0] val, input logic dir, input logic [XL-1:0] tgt);
    fu_valid[i]     = 1'b1;
    fu_rob_idx[i]   = RW'(rob);
    fu_prn[i]       = PW'(prn);
    fu_value[i]     = val;
    fu_direction[i] = dir;
    fu_target[i]    = tgt;
  endtask

  task automatic clear_fu();
    fu_valid = '0; fu_rob_idx = '0; fu_prn = '0;
    fu_value = '0; fu_direction = '0; fu_target = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; squash = 1'b0;
    clear_fu();
    tick(); tick();
    chk("ready_in_reset", fu_ready, 0);
    chk("reset_valid", CDB_valid, 0);
    chk("reset_fields", {CDB_ROB_idx, CDB_PRN, CDB_value, CDB_direction, CDB_target}, 0);
    chk("model_rr_reset", m_rr, 0);
    reset = 1'b0;
    #1 chk("ready_after_reset", fu_ready, 6'b111111);

    // single completion
    set_fu(2, 5, 17, 32'hDEAD_BEEF, 1'b1, 32'h100);
    tick(); clear_fu();
    tick();
    chk("single_valid", CDB_valid, 3'b001);
    chk("single_lane0", {CDB_ROB_idx[0], CDB_PRN[0], CDB_value[0], CDB_direction[0], CDB_target[0]},
        {5'd5, 6'd17, 32'hDEAD_BEEF, 1'b1, 32'h100});
    chk("single_rr", m_rr, 3);
    tick();
    chk("single_gone", CDB_valid, 3'b000);

    // overload from rr=0
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < N; i++) set_fu(i, i, i + 8, 32'h1000 + i, i[0], 32'h2000 + 4 * i);
    tick(); clear_fu();
    #1 chk("ovl_ready_pre", fu_ready, 6'b000111);
    tick();
    chk("ovl_b1_valid", CDB_valid, 3'b111);
    chk("ovl_b1_rob", CDB_ROB_idx, {5'd2, 5'd1, 5'd0});
    chk("ovl_b1_ready", fu_ready, 6'b111111);
    chk("ovl_rr1", m_rr, 3);
    tick();
    chk("ovl_b2_rob", CDB_ROB_idx, {5'd5, 5'd4, 5'd3});
    chk("ovl_rr2", m_rr, 0);
    tick();
    chk("ovl_done", CDB_valid, 3'b000);

    // wrap priority from rr=3
    reset = 1'b1; tick(); reset = 1'b0;
    set_fu(2, 9, 1, 32'h9, 1'b0, 32'h0);
    tick(); clear_fu();
    tick();
    set_fu(1, 1, 11, 32'hA1, 1'b0, 32'h11);
    set_fu(4, 4, 14, 32'hA4, 1'b1, 32'h14);
    set_fu(5, 5, 15, 32'hA5, 1'b0, 32'h15);
    tick(); clear_fu();
    tick();
    chk("wrap_valid", CDB_valid, 3'b111);
    chk("wrap_rob", CDB_ROB_idx, {5'd1, 5'd5, 5'd4});
    chk("wrap_rr", m_rr, 2);

    // squash with pending FU0/FU3 and incoming FU1
    set_fu(0, 20, 30, 32'h20, 1'b1, 32'h200);
    set_fu(3, 23, 33, 32'h23, 1'b0, 32'h230);
    tick(); clear_fu();
    squash = 1'b1;
    set_fu(1, 21, 31, 32'h21, 1'b1, 32'h210);
    #1 chk("squash_ready", fu_ready, 6'b000000);
    tick();
    squash = 1'b0; clear_fu();
    chk("squash_valid", CDB_valid, 3'b000);
    chk("squash_rr", m_rr, 2);
    tick();
    chk("squash_after", CDB_valid, 3'b000);

    // single-FU streaming
    for (int k = 0; k < 8; k++) begin
      set_fu(0, k, k + 32, 32'hC0DE_0000 + k, k[0], 32'h4000 + k);
      #1 chk("stream_ready", fu_ready[0], 1'b1);
      tick();
      if (k > 0) chk("stream_lane0", {CDB_valid, CDB_ROB_idx[0]}, {3'b001, RW'(k - 1)});
    end
    clear_fu();
    tick();
    chk("stream_last", {CDB_valid, CDB_ROB_idx[0]}, {3'b001, 5'd7});
    tick();
    chk("stream_idle", CDB_valid, 3'b000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
